// File: rtl/bcd_clock_ctrl.sv
// BCD hours:minutes clock with RUN / SET_H / SET_M modes, edge-detected buttons and a blink strobe.
// Define BCD_CLOCK_CTRL_AUTO_REPEAT_EN to auto-repeat btn_inc while it is held in a set mode.
module bcd_clock_ctrl #(
    parameter int BLINK_DIV = 8,
    parameter int HOLD_CYC  = 16,
    parameter int REP_CYC   = 4
) (
    input  logic       ck,
    input  logic       rs_n,
    input  logic       tick_in,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [7:0] hour_bcd,
    output logic [7:0] min_bcd,
    output logic [1:0] mode,
    output logic       blink
);

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        SET_H = 2'b01,
        SET_M = 2'b10
    } mode_e;

    mode_e      state;
    mode_e      state_nxt;
    logic       btn_mode_q;
    logic       btn_inc_q;
    logic       mode_edge;
    logic       inc_edge;
    logic       rep_fire;
    logic       inc_fire;
    logic [7:0] blink_cnt;

    function automatic logic [7:0] min_next(input logic [7:0] v);
        if (v[3:0] == 4'd9)
            return {(v[7:4] == 4'd5) ? 4'd0 : v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] hour_next(input logic [7:0] v);
        if (v == 8'h23)
            return 8'h00;
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    assign mode_edge = btn_mode & ~btn_mode_q;
    assign inc_edge  = btn_inc  & ~btn_inc_q;
    // A mode change in the same cycle swallows any increment.
    assign inc_fire  = (inc_edge | rep_fire) & ~mode_edge;
    assign mode      = state;

    // NOTE: next state defaults to the current state first, so no latch is inferred.
    always_comb begin
        state_nxt = state;
        if (mode_edge) begin
            case (state)
                RUN:     state_nxt = SET_H;
                SET_H:   state_nxt = SET_M;
                default: state_nxt = RUN;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge ck) begin
        if (!rs_n)
            state <= RUN;
        else
            state <= state_nxt;
    end

`ifdef BCD_CLOCK_CTRL_AUTO_REPEAT_EN
    // rep_cnt is zero when disarmed; an inc edge arms it and it then counts held cycles.
    logic [8:0] rep_cnt;
    logic       rep_phase;
    logic       rep_clr;
    logic [8:0] rep_limit;

    assign rep_clr   = ~btn_inc | mode_edge | (state == RUN);
    assign rep_limit = rep_phase ? 9'(REP_CYC + 1) : 9'(HOLD_CYC);
    assign rep_fire  = ~rep_clr & ~inc_edge & (rep_cnt != 9'd0) & (rep_cnt == rep_limit);

    always_ff @(posedge ck) begin
        if (!rs_n || rep_clr) begin
            rep_cnt   <= 9'd0;
            rep_phase <= 1'b0;
        end else if (inc_edge) begin
            rep_cnt   <= 9'd1;
            rep_phase <= 1'b0;
        end else if (rep_fire) begin
            rep_cnt   <= 9'd1;
            rep_phase <= 1'b1;
        end else if (rep_cnt != 9'd0) begin
            rep_cnt   <= rep_cnt + 9'd1;
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

    always_ff @(posedge ck) begin
        if (!rs_n) begin
            btn_mode_q <= 1'b1;
            btn_inc_q  <= 1'b1;
            hour_bcd   <= 8'h00;
            min_bcd    <= 8'h00;
            blink_cnt  <= 8'd0;
            blink      <= 1'b0;
        end else begin
            btn_mode_q <= btn_mode;
            btn_inc_q  <= btn_inc;

            case (state)
                RUN: begin
                    if (tick_in) begin
                        min_bcd <= min_next(min_bcd);
                        if (min_bcd == 8'h59)
                            hour_bcd <= hour_next(hour_bcd);
                    end
                end
                SET_H:   if (inc_fire) hour_bcd <= hour_next(hour_bcd);
                SET_M:   if (inc_fire) min_bcd  <= min_next(min_bcd);
                default: ;
            endcase

            // Divider restarts on every mode change and idles in RUN.
            if (state_nxt != state || state_nxt == RUN) begin
                blink_cnt <= 8'd0;
                blink     <= 1'b0;
            end else if (blink_cnt == 8'(BLINK_DIV - 1)) begin
                blink_cnt <= 8'd0;
                blink     <= ~blink;
            end else begin
                blink_cnt <= blink_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_bcd_clock_ctrl.sv
// Scoreboarded bench for bcd_clock_ctrl: an arithmetic minute/hour model predicts each cycle,
// a negedge monitor compares; honours BCD_CLOCK_CTRL_AUTO_REPEAT_EN like the design.
module tb_bcd_clock_ctrl;

    localparam int BLINK_DIV = 8;
    localparam int HOLD_CYC  = 16;
    localparam int REP_CYC   = 4;

    logic       ck       = 1'b0;
    logic       rs_n     = 1'b0;
    logic       tick_in  = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc  = 1'b0;
    logic [7:0] hour_bcd;
    logic [7:0] min_bcd;
    logic [1:0] mode;
    logic       blink;

    bcd_clock_ctrl #(
        .BLINK_DIV(BLINK_DIV),
        .HOLD_CYC (HOLD_CYC),
        .REP_CYC  (REP_CYC)
    ) dut (
        .ck      (ck),
        .rs_n    (rs_n),
        .tick_in (tick_in),
        .btn_mode(btn_mode),
        .btn_inc (btn_inc),
        .hour_bcd(hour_bcd),
        .min_bcd (min_bcd),
        .mode    (mode),
        .blink   (blink)
    );

    always #5 ck = ~ck;

    typedef struct packed {
        logic [31:0] cyc;
        logic [7:0]  h;
        logic [7:0]  m;
        logic [1:0]  md;
        logic        bl;
        logic        chk_bl;
    } exp_t;

    exp_t sb[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model: plain integers for time, mode index and cycles since mode entry.
    int m_h = 0, m_m = 0, m_mode = 0, m_age = 0, m_hold = 0;
    bit m_armed = 0, m_pbm = 1, m_pbi = 1;

    always @(posedge ck) cyc++;

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic check(input string name, input int c, input logic [7:0] got, input logic [7:0] req);
        n_checks++;
        if (got !== req) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got %h, required %h", name, c, got, req);
        end
    endtask

    always @(negedge ck) begin
        exp_t e;
        while (sb.size() > 0 && int'(sb[0].cyc) <= cyc) begin
            e = sb.pop_front();
            if (int'(e.cyc) < cyc) begin
                n_checks++;
                n_errors++;
                $display("FAIL stale_expectation cycle %0d: got cycle %0d, required cycle %0d", cyc, cyc, e.cyc);
            end else begin
                check("hour_bcd", cyc, hour_bcd, e.h);
                check("min_bcd", cyc, min_bcd, e.m);
                check("mode", cyc, {6'd0, mode}, {6'd0, e.md});
                if (e.chk_bl)
                    check("blink", cyc, {7'd0, blink}, {7'd0, e.bl});
            end
        end
    end

    // Drive one cycle of inputs, advance the model across that edge and queue its prediction.
    task automatic step(input bit t, input bit bm, input bit bi, input bit r = 1'b1);
        bit   me, ie, fire;
        exp_t e;
        rs_n     = r;
        tick_in  = t;
        btn_mode = bm;
        btn_inc  = bi;
        if (!r) begin
            m_h = 0; m_m = 0; m_mode = 0; m_age = 0;
            m_armed = 0; m_pbm = 1; m_pbi = 1;
        end else begin
            me   = bm && !m_pbm;
            ie   = bi && !m_pbi;
            fire = 0;
            if (m_mode != 0 && !me) begin
                if (ie) begin
                    fire = 1; m_armed = 1; m_hold = 0;
                end
`ifdef BCD_CLOCK_CTRL_AUTO_REPEAT_EN
                else if (m_armed && bi) begin
                    m_hold++;
                    if (m_hold >= HOLD_CYC && (m_hold - HOLD_CYC) % (REP_CYC + 1) == 0)
                        fire = 1;
                end
`endif
            end
            if (!bi || me || m_mode == 0)
                m_armed = 0;
            if (m_mode == 0 && t) begin
                m_m++;
                if (m_m == 60) begin
                    m_m = 0;
                    m_h = (m_h + 1) % 24;
                end
            end else if (m_mode == 1 && fire) begin
                m_h = (m_h + 1) % 24;
            end else if (m_mode == 2 && fire) begin
                m_m = (m_m + 1) % 60;
            end
            if (me) begin
                m_mode = (m_mode + 1) % 3;
                m_age  = 0;
            end else begin
                m_age++;
            end
            m_pbm = bm;
            m_pbi = bi;
        end
        e.cyc    = 32'(cyc + 1);
        e.h      = to_bcd(m_h);
        e.m      = to_bcd(m_m);
        e.md     = 2'(m_mode);
        e.bl     = (m_mode != 0) && ((m_age / BLINK_DIV) % 2 == 1);
        e.chk_bl = 1'b1;
        sb.push_back(e);
        @(posedge ck);
        #1;
    endtask

    // Scenario-level expectation, fixed by the bench author, for the state visible now.
    task automatic expect_now(input logic [7:0] h, input logic [7:0] m, input logic [1:0] md,
                              input bit chk_bl, input bit bl);
        exp_t e;
        e.cyc    = 32'(cyc);
        e.h      = h;
        e.m      = m;
        e.md     = md;
        e.bl     = bl;
        e.chk_bl = chk_bl;
        sb.push_back(e);
    endtask

    task automatic press_inc(input bit random_ticks);
        step(random_ticks ? 1'($urandom_range(0, 1)) : 1'b0, 1'b0, 1'b1);
        step(random_ticks ? 1'($urandom_range(0, 1)) : 1'b0, 1'b0, 1'b0);
    endtask

    task automatic press_mode(input bit t);
        step(t, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        // Reset with both buttons held, then release reset while still held: no edges.
        step(0, 1, 1, 0);
        step(0, 1, 1, 0);
        step(0, 1, 1, 0);
        step(0, 1, 1);
        step(0, 0, 0);
        expect_now(8'h00, 8'h00, 2'b00, 1, 0);

        // 60 ticks in RUN with random gaps; btn_inc activity must not matter.
        for (int i = 0; i < 60; i++) begin
            step(1, 0, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) step(0, 0, 1'($urandom_range(0, 1)));
        end
        step(0, 0, 0);
        expect_now(8'h01, 8'h00, 2'b00, 1, 0);

        // Run up to 23:59, then one tick wraps to 00:00.
        for (int i = 0; i < 1379; i++) step(1, 0, 0);
        expect_now(8'h23, 8'h59, 2'b00, 1, 0);
        step(1, 0, 0);
        expect_now(8'h00, 8'h00, 2'b00, 1, 0);

        // Leave RUN with a tick in the same cycle: the tick still counts.
        step(1, 1, 0);
        expect_now(8'h00, 8'h01, 2'b01, 1, 0);
        step(0, 0, 0);
        for (int i = 0; i < 25; i++) begin
            press_inc(1);
            repeat ($urandom_range(0, 2)) step(1'($urandom_range(0, 1)), 0, 0);
        end
        expect_now(8'h01, 8'h01, 2'b01, 0, 0);

        // SET_M: walk minutes to 59, wrap to 00 without touching hours.
        press_mode(0);
        for (int i = 0; i < 58; i++) press_inc(1);
        expect_now(8'h01, 8'h59, 2'b10, 0, 0);
        press_inc(1);
        expect_now(8'h01, 8'h00, 2'b10, 0, 0);

        // Mode and inc edges together, with a tick: back to RUN, nothing increments.
        step(1, 1, 1);
        expect_now(8'h01, 8'h00, 2'b00, 1, 0);
        step(0, 0, 0);

        // Hold btn_inc for 40 cycles in SET_M starting at minute 00.
        press_mode(0);
        press_mode(0);
        expect_now(8'h01, 8'h00, 2'b10, 1, 0);
        repeat (40) step(0, 0, 1);
        step(0, 0, 0);
`ifdef BCD_CLOCK_CTRL_AUTO_REPEAT_EN
        expect_now(8'h01, 8'h06, 2'b10, 0, 0);
`else
        expect_now(8'h01, 8'h01, 2'b10, 0, 0);
`endif

        // Reset in the middle of SET_H with btn_inc held, then keep holding after reset.
        press_mode(0);
        press_mode(0);
        repeat (5) step(0, 0, 1);
        expect_now(8'h02, 8'h01, 2'b01, 0, 0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        expect_now(8'h00, 8'h00, 2'b00, 1, 0);
        repeat (20) step(0, 0, 1);
        expect_now(8'h00, 8'h00, 2'b00, 1, 0);
        step(0, 0, 0);

        // Random traffic across all modes, with occasional resets.
        for (int i = 0; i < 800; i++) begin
            step(1'($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 15) == 0),
                 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 199) != 0));
        end
        step(0, 0, 0);

        repeat (4) @(negedge ck);
        if (sb.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
